// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a second entry so that in_ready is driven from a flop.
`timescale 1ns/1ps

module pipe_stage_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    logic do_accept;
    logic do_release;

    assign do_accept  = in_valid && in_ready;
    assign do_release = out_valid && out_ready;

    // Stall counter: saturates and ignores flush.
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

`ifdef PIPE_STAGE_SKID_EN

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [DATA_WIDTH-1:0] skid_d;
    logic                  in_ready_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (do_accept) begin
                    main_d  = in_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (do_accept && do_release) begin
                    main_d = in_data;
                end else if (do_accept) begin
                    skid_d  = in_data;
                    state_d = ST_FULL;
                end else if (do_release) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a release can happen.
                if (do_release) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Flush kills every entry but leaves the payload registers alone.
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

`else

    logic                  valid_q;
    logic                  valid_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (do_accept) begin
            valid_d = 1'b1;
        end else if (do_release) begin
            valid_d = 1'b0;
        end
        if (do_accept && !flush_i) begin
            data_d = in_data;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg against a FIFO-queue reference model.
// Two instances share stimulus: default counter width and a 3-bit counter for saturation.
`timescale 1ns/1ps

module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int CWS = 3;
    localparam longint CNT_MAX = 65535;
    localparam longint CNT_MAX_S = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n = 1'b0;
    logic           flush_i = 1'b0;
    logic           in_valid = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic           out_ready = 1'b0;
    logic           in_ready;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic [CW-1:0]  stall_cnt;
    logic           in_ready_s;
    logic           out_valid_s;
    logic [DW-1:0]  out_data_s;
    logic [CWS-1:0] stall_cnt_s;

    pipe_stage_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CWS)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .stall_cnt(stall_cnt_s)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: queue of held words, last word that sat at the head, raw stall count.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] last_head = '0;
    longint        raw_cnt = 0;
    bit            model_ok = 1'b0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit exp_in_ready(input bit ordy);
`ifdef PIPE_STAGE_SKID_EN
        return (mq.size() < 2);
`else
        return (mq.size() == 0) || ordy;
`endif
    endfunction

    function automatic longint sat(input longint v, input longint m);
        return (v > m) ? m : v;
    endfunction

    // One clock: drive inputs, check against the model at negedge, advance the model at posedge.
    task automatic step(input bit rst, input bit fl, input bit iv, input logic [DW-1:0] d, input bit ordy);
        bit acc;
        bit rel;
        bit stl;
        logic [DW-1:0] exp_data;
        rst_n     = !rst;
        flush_i   = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        exp_data = (mq.size() > 0) ? mq[0] : last_head;
        if (model_ok) begin
            chk_eq("in_ready",    64'(in_ready),    64'(exp_in_ready(ordy)));
            chk_eq("out_valid",   64'(out_valid),   64'(mq.size() > 0));
            chk_eq("out_data",    64'(out_data),    64'(exp_data));
            chk_eq("stall_cnt",   64'(stall_cnt),   64'(sat(raw_cnt, CNT_MAX)));
            chk_eq("in_ready_s",  64'(in_ready_s),  64'(exp_in_ready(ordy)));
            chk_eq("out_valid_s", 64'(out_valid_s), 64'(mq.size() > 0));
            chk_eq("out_data_s",  64'(out_data_s),  64'(exp_data));
            chk_eq("stall_cnt_s", 64'(stall_cnt_s), 64'(sat(raw_cnt, CNT_MAX_S)));
        end
        acc = iv && exp_in_ready(ordy);
        rel = (mq.size() > 0) && ordy;
        stl = (mq.size() > 0) && !ordy;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            last_head = '0;
            raw_cnt   = 0;
            model_ok  = 1'b1;
        end else begin
            if (stl) raw_cnt++;
            if (rel) void'(mq.pop_front());
            if (fl) mq.delete();
            else if (acc) mq.push_back(d);
            if (mq.size() > 0) last_head = mq[0];
        end
        #1;
    endtask

    initial begin
        // Reset with a pending upstream word.
        step(1, 0, 1, 32'hDEADBEEF, 0);
        step(1, 0, 1, 32'hDEADBEEF, 0);
        chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
        chk_eq("rst_out_data",  64'(out_data),  64'd0);
        chk_eq("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        step(0, 0, 0, 32'h0, 0);
        chk_eq("rst_in_ready",  64'(in_ready),  64'd1);

        // Streaming at full throughput.
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 1, DW'(k), 1);
            chk_eq("stream_valid", 64'(out_valid), 64'd1);
            chk_eq("stream_data",  64'(out_data),  64'(k));
        end
        step(0, 0, 0, 32'h0, 1);
        chk_eq("stream_drained", 64'(out_valid), 64'd0);
        chk_eq("stream_cnt",     64'(stall_cnt), 64'd0);

        // Stall holding 0xA5 while 0x5A is offered.
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 1, 32'hA5, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 32'h5A, 0);
        chk_eq("stall_cnt5",  64'(stall_cnt), 64'd5);
        chk_eq("stall_data",  64'(out_data),  64'hA5);
        chk_eq("stall_ready", 64'(in_ready),  64'd0);
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        chk_eq("stall_drained", 64'(out_valid), 64'd0);

        // Flush with same-cycle accept of 0x77 and release of 0x66.
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 1, 32'h66, 0);
        chk_eq("flush_held", 64'(out_data), 64'h66);
        step(0, 1, 1, 32'h77, 1);
        chk_eq("flush_valid", 64'(out_valid), 64'd0);
        step(0, 0, 0, 32'h0, 1);
        chk_eq("flush_no77", 64'(out_valid), 64'd0);

        // Counter saturation on the 3-bit instance, surviving a flush.
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 1, 32'h11, 0);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 32'h0, 0);
        chk_eq("sat_cnt",   64'(stall_cnt_s), 64'd7);
        chk_eq("wide_cnt",  64'(stall_cnt),   64'd10);
        step(0, 1, 0, 32'h0, 0);
        chk_eq("sat_flush", 64'(stall_cnt_s), 64'd7);
        chk_eq("sat_empty", 64'(out_valid_s), 64'd0);

        // Random traffic with occasional flush and reset.
        step(1, 0, 0, 32'h0, 0);
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 7, DW'($urandom()), $urandom_range(0, 9) < 6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised pipeline stage register that replaces the hand-written per-stage registers between decode/execute and later stages. It carries a packed payload bus of arbitrary width under a valid/ready handshake, with synchronous flush and a saturating stall-cycle counter. An optional 2-entry skid buffer registers upstream backpressure. One instance sits between each pair of pipeline stages; the stage's control and data fields are concatenated into `in_data`.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: width of the packed payload.
- `CNT_WIDTH`, default 16: width of the stall counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush_i`  in  1  synchronous kill of all held entries, active-high.
- `in_valid`  in  1  upstream holds a valid payload.
- `in_ready`  out  1  stage can accept this cycle.
- `in_data`  in  DATA_WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts this cycle; low means stall.
- `out_data`  out  DATA_WIDTH  payload to downstream.
- `stall_cnt`  out  CNT_WIDTH  cycles with `out_valid && !out_ready`.

## Operation
- An accept is `in_valid && in_ready` at a rising edge. A release is `out_valid && out_ready` at a rising edge.
- Payload registers load only on accept. Bubbles never overwrite held data, and unused data keeps its old value.
- Main register behaviour (no skid):
  - `in_ready = !out_valid || out_ready`, combinational.
  - On accept: main data ← `in_data`, and `out_valid` ← 1.
  - On release without accept: `out_valid` ← 0.
  - On simultaneous release and accept: the new data loads and `out_valid` stays 1.
- Flush:
  - Clears all valid bits at the next edge. Data registers are untouched.
  - Flush beats a same-cycle accept: the payload is dropped, and upstream sees it as consumed.
  - A same-cycle release still completes downstream.
- Stall counter:
  - Increments by 1 on each edge where `out_valid && !out_ready`.
  - Saturates at 2^CNT_WIDTH−1 (no wrap).
  - Unaffected by flush; cleared only by reset.
- Reset (`rst_n` = 0 at an edge):
  - `out_valid` = 0, `out_data` = 0, and skid data = 0.
  - `stall_cnt` = 0.
  - `in_ready` = 1 from the next cycle.
  - Reset overrides flush and any handshake, including mid-transfer.

## Timing
- Latency: an accept at edge N presents `out_data`/`out_valid` from edge N onward, i.e. one register stage. There is no combinational path from `in_data` to `out_data`.
- No skid: `in_ready` has a combinational path from `out_ready`. Full throughput is one transfer per cycle.
- With skid: `in_ready` is a flop output, so there is no combinational `out_ready`→`in_ready` path. Full throughput is still one transfer per cycle.
- Handshake rules:
  - `out_valid` never drops without a release, flush or reset.
  - `out_data` is stable while `out_valid && !out_ready`.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: adds a second (skid) entry and a 3-state FSM.
  - States are EMPTY (main invalid), ONE (main valid, skid empty) and FULL (both valid).
  - `in_ready` is registered and equals 1 in EMPTY and ONE, 0 in FULL.
  - EMPTY→ONE on accept.
  - ONE→FULL on accept without release: incoming data goes to skid.
  - ONE→ONE on accept with release: incoming data goes to main.
  - ONE→EMPTY on release without accept.
  - FULL→ONE on release: skid moves to main. No accept is possible in FULL.
  - Flush in any state → EMPTY.
  - Ordering is strictly FIFO.
- `PIPE_STAGE_SKID_EN` undefined: single register with combinational `in_ready` as described under Operation. There is no skid storage and no FSM.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with `in_valid` = 1 and `in_data` = 0xDEADBEEF. Required: `out_valid` = 0, `out_data` = 0, `stall_cnt` = 0, then `in_ready` = 1 after release.
- Streaming: `out_ready` = 1, push 0x1, 0x2, 0x3 on consecutive cycles. Required: out sequence 0x1, 0x2, 0x3 one cycle later, no gaps, `stall_cnt` = 0.
- Stall: hold 0xA5 with `out_ready` = 0 for 5 cycles. Required: `out_data` stays 0xA5 and `stall_cnt` = 5.
  - No skid: `in_ready` = 0.
  - Skid: one more word 0x5A is accepted, then `in_ready` = 0. After release, 0xA5 comes out, then 0x5A.
- Flush priority: in the same cycle assert `flush_i`, accept 0x77 and release the held 0x66. Required: 0x66 delivered, next cycle `out_valid` = 0, and 0x77 never appears.
- Counter saturation: `CNT_WIDTH` = 3, stall for 10 cycles. Required: `stall_cnt` = 7. After a flush, `stall_cnt` is still 7.
